// File: rtl/pem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pem_pkg : shared types and helpers for the pulse edge timer        |
// | Rev 1.0 : initial release                                          |
// +--------------------------------------------------------------------+
package pem_pkg;

  localparam int PEM_CNT_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_MEAS  = 3'd2,
    ST_CLOSE = 3'd3,
    ST_DONE  = 3'd4
  } pem_state_e;

  // Increment that sticks at max_v instead of wrapping.
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input logic [63:0] max_v);
    return (v >= max_v) ? max_v : v + 64'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sig_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sig_conditioner : 2-FF synchroniser, FILT_LEN glitch filter, edges |
// | Rev 1.0 : initial release                                          |
// +--------------------------------------------------------------------+
module sig_conditioner #(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic rest,
  input  logic sig_in,
  output logic sig_f,
  output logic rise,
  output logic fall
);

  localparam int FW = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN);
  localparam logic [FW-1:0] CNT_LAST = FW'(FILT_LEN - 1);

  logic [1:0]    sync_q, sync_d;
  logic [FW-1:0] cnt_q, cnt_d;
  logic          sig_f_q, sig_f_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic          flip;

  // The strobes are registered alongside sig_f so a rise cycle always sees sig_f=1.
  always_comb begin
    sync_d  = {sync_q[0], sig_in};
    cnt_d   = '0;
    sig_f_d = sig_f_q;
    flip    = 1'b0;
    if (sync_q[1] != sig_f_q) begin
      if (cnt_q == CNT_LAST) begin
        sig_f_d = sync_q[1];
        flip    = 1'b1;
      end else begin
        cnt_d = cnt_q + FW'(1);
      end
    end
    rise_d = flip & sync_q[1];
    fall_d = flip & ~sync_q[1];
  end

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      sig_f_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      sig_f_q <= sig_f_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign sig_f = sig_f_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule
`default_nettype wire

// File: rtl/pulse_edge_timer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pulse_edge_timer : reciprocal period / duty measurement core       |
// | Rev 1.0 : initial release                                          |
// +--------------------------------------------------------------------+
module pulse_edge_timer
  import pem_pkg::*;
#(
  parameter int CNT_W          = PEM_CNT_W,
  parameter int FILT_LEN       = 3,
  parameter int GATE_CYCLES    = 50000000,
  parameter int TIMEOUT_CYCLES = 100000000
) (
  input  logic             clk,
  input  logic             rest,
  input  logic             sig_in,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cycles_cnt,
  output logic [CNT_W-1:0] ref_cnt,
  output logic [CNT_W-1:0] high_cnt,
  output logic             timeout,
  output logic             ovf
);

  localparam int GW = $clog2(GATE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [GW-1:0]    GATE_V  = GW'(GATE_CYCLES);
  localparam logic [TW-1:0]    TO_V    = TW'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] v);
    return CNT_W'(sat_inc(64'(v), 64'(CNT_MAX)));
  endfunction

  logic sig_f, rise, unused_fall;

  sig_conditioner #(.FILT_LEN(FILT_LEN)) u_cond (
    .clk    (clk),
    .rest   (rest),
    .sig_in (sig_in),
    .sig_f  (sig_f),
    .rise   (rise),
    .fall   (unused_fall)
  );

  pem_state_e       state_q, state_d;
  logic [CNT_W-1:0] n_q, n_d, ref_q, ref_d, high_q, high_d;
  logic             ovf_i_q, ovf_i_d;
  logic [GW-1:0]    gate_q, gate_d, gate_nx;
  logic [TW-1:0]    tmr_q, tmr_d, tmr_nx;
  logic             gate_hit, tmr_hit, to_path, closing;

  logic             busy_q, busy_d, done_q, done_d, to_q, to_d, ovf_q, ovf_d;
  logic [CNT_W-1:0] cyc_out_q, cyc_out_d, ref_out_q, ref_out_d, high_out_q, high_out_d;

  // The gate timer is separate from ref so the window still closes when ref saturates.
  always_comb begin
    gate_nx  = (gate_q >= GATE_V) ? gate_q : gate_q + GW'(1);
    tmr_nx   = (tmr_q >= TO_V) ? tmr_q : tmr_q + TW'(1);
    gate_hit = (gate_nx >= GATE_V);
    tmr_hit  = (tmr_nx >= TO_V);
    closing  = rise && (((state_q == ST_MEAS) && gate_hit) || (state_q == ST_CLOSE));
  end

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    to_path = 1'b0;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_ARM;
      ST_ARM: begin
        if (rise) state_d = ST_MEAS;
        else if (tmr_hit) begin
          state_d = ST_DONE;
          to_path = 1'b1;
        end
      end
      ST_MEAS: begin
        if (closing)       state_d = ST_DONE;
        else if (gate_hit) state_d = ST_CLOSE;
      end
      ST_CLOSE: begin
        if (rise) state_d = ST_DONE;
        else if (tmr_hit) begin
          state_d = ST_DONE;
          to_path = 1'b1;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      to_path = 1'b0;
    end
  end

  always_comb begin
    n_d     = n_q;
    ref_d   = ref_q;
    high_d  = high_q;
    ovf_i_d = ovf_i_q;
    gate_d  = gate_q;
    tmr_d   = tmr_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          n_d     = '0;
          ref_d   = '0;
          high_d  = '0;
          ovf_i_d = 1'b0;
          gate_d  = '0;
          tmr_d   = '0;
        end
      end
      ST_ARM: begin
        tmr_d = tmr_nx;
        if (rise) begin
          n_d     = '0;
          ref_d   = '0;
          high_d  = sig_f ? CNT_W'(1) : '0;
          ovf_i_d = 1'b0;
          gate_d  = '0;
          tmr_d   = '0;
        end
      end
      ST_MEAS, ST_CLOSE: begin
        ref_d   = inc(ref_q);
        ovf_i_d = ovf_i_q | (&ref_q);
        gate_d  = gate_nx;
        tmr_d   = (state_q == ST_CLOSE) ? tmr_nx : '0;
        if (rise) begin
          n_d     = inc(n_q);
          ovf_i_d = ovf_i_d | (&n_q);
        end
        if (sig_f && !closing) begin
          high_d  = inc(high_q);
          ovf_i_d = ovf_i_d | (&high_q);
        end
      end
      default: ;
    endcase
  end

  // Results are captured only on the edge into DONE so readback is stable while busy.
  always_comb begin
    cyc_out_d  = cyc_out_q;
    ref_out_d  = ref_out_q;
    high_out_d = high_out_q;
    to_d       = to_q;
    ovf_d      = ovf_q;
    done_d     = (state_d == ST_DONE);
    busy_d     = (state_d == ST_ARM) || (state_d == ST_MEAS) || (state_d == ST_CLOSE);
    if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
      if (to_path) begin
        cyc_out_d  = '0;
        ref_out_d  = '0;
        high_out_d = '0;
        to_d       = 1'b1;
        ovf_d      = 1'b0;
      end else begin
        cyc_out_d  = n_d;
        ref_out_d  = ref_d;
        high_out_d = high_d;
        to_d       = 1'b0;
        ovf_d      = ovf_i_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      n_q        <= '0;
      ref_q      <= '0;
      high_q     <= '0;
      ovf_i_q    <= 1'b0;
      gate_q     <= '0;
      tmr_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      to_q       <= 1'b0;
      ovf_q      <= 1'b0;
      cyc_out_q  <= '0;
      ref_out_q  <= '0;
      high_out_q <= '0;
    end else begin
      n_q        <= n_d;
      ref_q      <= ref_d;
      high_q     <= high_d;
      ovf_i_q    <= ovf_i_d;
      gate_q     <= gate_d;
      tmr_q      <= tmr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      to_q       <= to_d;
      ovf_q      <= ovf_d;
      cyc_out_q  <= cyc_out_d;
      ref_out_q  <= ref_out_d;
      high_out_q <= high_out_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign timeout    = to_q;
  assign ovf        = ovf_q;
  assign cycles_cnt = cyc_out_q;
  assign ref_cnt    = ref_out_q;
  assign high_cnt   = high_out_q;

endmodule
`default_nettype wire

// File: tb/tb_pulse_edge_timer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_pulse_edge_timer : randomized bench with a period/duty model    |
// | Rev 1.0 : initial release                                          |
// +--------------------------------------------------------------------+
module tb_pulse_edge_timer;

  localparam int NI = 4;
  localparam int G_TAB [NI] = '{100, 95, 101, 300};
  localparam int LIMIT = 3000;

  logic clk = 1'b0;
  logic rest, sig_in, start, abort;
  logic        busy_a [NI];
  logic        done_a [NI];
  logic        to_a   [NI];
  logic        ovf_a  [NI];
  logic [31:0] cyc_a  [NI];
  logic [31:0] ref_a  [NI];
  logic [31:0] high_a [NI];

  always #5 clk = ~clk;

  for (genvar i = 0; i < NI; i++) begin : g_dut
    localparam int CW = (i == 3) ? 8 : 32;
    logic [CW-1:0] c_w, r_w, h_w;
    pulse_edge_timer #(
      .CNT_W          (CW),
      .FILT_LEN       (3),
      .GATE_CYCLES    (G_TAB[i]),
      .TIMEOUT_CYCLES (200)
    ) u_dut (
      .clk        (clk),
      .rest       (rest),
      .sig_in     (sig_in),
      .start      (start),
      .abort      (abort),
      .busy       (busy_a[i]),
      .done       (done_a[i]),
      .cycles_cnt (c_w),
      .ref_cnt    (r_w),
      .high_cnt   (h_w),
      .timeout    (to_a[i]),
      .ovf        (ovf_a[i])
    );
    assign cyc_a[i]  = 32'(c_w);
    assign ref_a[i]  = 32'(r_w);
    assign high_a[i] = 32'(h_w);
  end

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Square wave source: period per, high hi, optional sub-FILT_LEN glitch in the low phase.
  bit wave_en = 0;
  bit glitch_en = 0;
  int per = 10, hi = 3, glen = 1;

  initial begin
    int ph;
    ph = 0;
    sig_in = 1'b0;
    forever begin
      @(negedge clk);
      if (!wave_en) begin
        sig_in = 1'b0;
        ph = 0;
      end else begin
        sig_in = (ph < hi) || (glitch_en && ph >= hi + 4 && ph < hi + 4 + glen);
        ph = (ph + 1 >= per) ? 0 : ph + 1;
      end
    end
  end

  // Whole-period window: N is the smallest period count covering the gate.
  task automatic model(input int g, input int cw, output logic [31:0] en, output logic [31:0] er,
                       output logic [31:0] eh, output logic eo);
    longint n, mx;
    n  = (g + per - 1) / per;
    mx = (64'd1 << cw) - 1;
    eo = (n > mx) || (n * per > mx) || (n * hi > mx);
    en = 32'((n > mx) ? mx : n);
    er = 32'((n * per > mx) ? mx : n * per);
    eh = 32'((n * hi > mx) ? mx : n * hi);
  endtask

  logic [31:0] last_c [NI];
  logic [31:0] last_r [NI];
  logic [31:0] last_h [NI];
  logic        last_o [NI];
  logic        last_t [NI];

  task automatic settle();
    wave_en = 0;
    repeat (30) @(negedge clk);
    wave_en = 1;
    repeat (60) @(negedge clk);
  endtask

  task automatic run_meas(input bit exp_to, input string name);
    logic [31:0] en, er, eh;
    logic        eo;
    int          seen [NI];
    int          lat;
    bit          all;
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < NI; i++) seen[i] = 0;
    lat = 0;
    for (int cyc = 1; cyc <= LIMIT; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == 1) begin
        start = 1'b0;
        chk({name, ":busy"}, 64'(busy_a[0]), 64'd1);
      end
      for (int i = 0; i < NI; i++) begin
        if (done_a[i]) begin
          seen[i]++;
          if (seen[i] == 1) begin
            if (i == 0) lat = cyc;
            if (exp_to) begin
              en = 0; er = 0; eh = 0; eo = 0;
            end else begin
              model(G_TAB[i], (i == 3) ? 8 : 32, en, er, eh, eo);
            end
            chk($sformatf("%s:cyc[%0d]", name, i), 64'(cyc_a[i]), 64'(en));
            chk($sformatf("%s:ref[%0d]", name, i), 64'(ref_a[i]), 64'(er));
            chk($sformatf("%s:high[%0d]", name, i), 64'(high_a[i]), 64'(eh));
            chk($sformatf("%s:ovf[%0d]", name, i), 64'(ovf_a[i]), 64'(eo));
            chk($sformatf("%s:to[%0d]", name, i), 64'(to_a[i]), 64'(exp_to));
            chk($sformatf("%s:busy_done[%0d]", name, i), 64'(busy_a[i]), 64'd0);
            last_c[i] = en; last_r[i] = er; last_h[i] = eh; last_o[i] = eo; last_t[i] = exp_to;
          end
        end
      end
      all = 1;
      for (int i = 0; i < NI; i++) if (seen[i] == 0) all = 0;
      if (all) break;
    end
    repeat (5) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) if (done_a[i]) seen[i]++;
    end
    for (int i = 0; i < NI; i++)
      chk($sformatf("%s:done_count[%0d]", name, i), 64'(seen[i]), 64'd1);
    if (exp_to) chk({name, ":to_latency_ok"}, 64'(lat >= 195 && lat <= 205), 64'd1);
  endtask

  task automatic check_zero(input string name);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("%s:busy[%0d]", name, i), 64'(busy_a[i]), 64'd0);
      chk($sformatf("%s:done[%0d]", name, i), 64'(done_a[i]), 64'd0);
      chk($sformatf("%s:to[%0d]", name, i), 64'(to_a[i]), 64'd0);
      chk($sformatf("%s:ovf[%0d]", name, i), 64'(ovf_a[i]), 64'd0);
      chk($sformatf("%s:cyc[%0d]", name, i), 64'(cyc_a[i]), 64'd0);
      chk($sformatf("%s:ref[%0d]", name, i), 64'(ref_a[i]), 64'd0);
      chk($sformatf("%s:high[%0d]", name, i), 64'(high_a[i]), 64'd0);
    end
  endtask

  initial begin
    int dones;
    rest = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    repeat (5) @(negedge clk);
    check_zero("reset");
    rest = 1'b1;

    per = 10; hi = 3; glitch_en = 0;
    settle();
    run_meas(0, "sq10");

    glitch_en = 1; glen = 1;
    run_meas(0, "glitch1");
    glen = 2;
    run_meas(0, "glitch2");

    for (int k = 0; k < 5; k++) begin
      per = $urandom_range(24, 10);
      hi  = $urandom_range(per - 7, 3);
      glitch_en = $urandom_range(1, 0);
      glen = $urandom_range(2, 1);
      settle();
      run_meas(0, $sformatf("rand%0d", k));
    end

    wave_en = 0;
    repeat (40) @(negedge clk);
    run_meas(1, "timeout");

    per = 10; hi = 3; glitch_en = 0;
    settle();
    run_meas(0, "after_to");

    // Abort with a simultaneous start while every instance is mid-window.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < NI; i++)
      chk($sformatf("abort:busy[%0d]", i), 64'(busy_a[i]), 64'd0);
    dones = 0;
    repeat (400) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) if (done_a[i]) dones++;
    end
    chk("abort:no_done", 64'(dones), 64'd0);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("abort:cyc[%0d]", i), 64'(cyc_a[i]), 64'(last_c[i]));
      chk($sformatf("abort:ref[%0d]", i), 64'(ref_a[i]), 64'(last_r[i]));
      chk($sformatf("abort:high[%0d]", i), 64'(high_a[i]), 64'(last_h[i]));
      chk($sformatf("abort:ovf[%0d]", i), 64'(ovf_a[i]), 64'(last_o[i]));
      chk($sformatf("abort:to[%0d]", i), 64'(to_a[i]), 64'(last_t[i]));
    end

    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    rest = 1'b0;
    #2;
    check_zero("midreset");
    repeat (3) @(negedge clk);
    check_zero("midreset_hold");
    rest = 1'b1;
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pulse_edge_timer.md
Name: pulse_edge_timer

Overview:
Reciprocal (equal-precision) period and duty measurement core for the conditioned trigger input.
- Conditions the raw pulse (synchroniser plus glitch filter).
- Opens a gate on a rising edge and closes it on the first rising edge after a minimum gate time, so every window spans a whole number of input periods.
- Presents whole-window cycle, reference-clock and high-time counts to the SPI command/readback layer with a start/done handshake.

Parameters:
CNT_W, 32, width of all count outputs
FILT_LEN, 3, consecutive equal synchronised samples required before the filtered signal changes (>=1)
GATE_CYCLES, 50000000, minimum gate length in clk cycles (1 s at 50 MHz)
TIMEOUT_CYCLES, 100000000, clk cycles without a rising edge in ARM or CLOSE before abandoning

Ports:
clk  in  1  system clock
rest  in  1  reset, asynchronous, active-low
sig_in  in  1  raw asynchronous pulse input
start  in  1  one-cycle request to begin a measurement
abort  in  1  one-cycle request to cancel a measurement
busy  out  1  high from accepted start until done or abort
done  out  1  one-cycle pulse when results are updated
cycles_cnt  out  CNT_W  rising edges counted in the window (N)
ref_cnt  out  CNT_W  clk cycles between opening and closing edges
high_cnt  out  CNT_W  clk cycles with filtered signal high inside the window
timeout  out  1  last measurement ended by timeout
ovf  out  1  a counter saturated during the last measurement

Behaviour:
- Reset (rest=0, async): FSM to IDLE; busy, done, timeout, ovf = 0; all counts = 0; synchroniser and filter cleared to 0.
- Conditioning: 2-FF synchroniser, then filter. sig_f takes the synced value only after FILT_LEN consecutive equal samples. rise/fall strobes are 1-cycle pulses on sig_f transitions.
- Conditioning latency is a fixed 2+FILT_LEN cycles, identical for both edges, so it adds no bias. Pulses shorter than FILT_LEN cycles are dropped.
- FSM states: IDLE, ARM, MEAS, CLOSE, DONE.
- IDLE: start=1 -> ARM. On entry, clear internal counters and the idle timer; set busy=1. start is ignored in all other states.
- ARM: waits for rise.
  - On rise: ref=0, N=0, high=1 if sig_f=1 that cycle -> MEAS.
  - If the idle timer reaches TIMEOUT_CYCLES -> DONE with timeout path.
- MEAS: each cycle, elapsed (ref) +1 and high +1 when sig_f=1. Each rise: N+1.
  - A rise that coincides with elapsed >= GATE_CYCLES (elapsed value after this cycle's increment) closes the window. It counts in N, adds nothing to high -> DONE.
  - When elapsed reaches GATE_CYCLES with no coincident rise -> CLOSE.
- CLOSE: same counting as MEAS. The first rise closes the window (included in N) -> DONE. The idle timer restarts on entry; reaching TIMEOUT_CYCLES with no rise -> timeout path.
- Result for a square wave with period P and high time H over N periods: ref=N*P, high=N*H, cycles=N.
- DONE (1 cycle): register the outputs, done=1, busy=0 -> IDLE.
  - Normal path: timeout=0; ovf = any internal saturation.
  - Timeout path: all counts = 0, timeout=1, ovf=0.
- Saturation: internal counters stick at all-ones and set an internal ovf flag; no wrap.
- abort: in any non-IDLE state, go to IDLE next cycle with busy=0, no done pulse; outputs keep their previous values.
- Precedence: abort beats start, closing edge and timeout in the same cycle.
- Outputs change only in the DONE cycle (or on reset) and hold until the next DONE, so readback is stable while busy.
- rest asserted mid-measurement: immediate return to reset values; no done.

Decomposition:
- Package pem_pkg holds:
  - FSM state enum (IDLE, ARM, MEAS, CLOSE, DONE)
  - CNT_W default constant
  - saturating-increment function
- Sub-module sig_conditioner holds the synchroniser, FILT_LEN filter and rise/fall strobes. It is reused by the trigger path.

Test Plan:
1. GATE_CYCLES=100, FILT_LEN=3, square wave P=10, H=3, start -> done after the window; cycles=10, ref=100, high=30, timeout=0, ovf=0.
2. Same setup with 1-cycle and 2-cycle glitches injected mid-low -> results identical to scenario 1.
3. GATE_CYCLES=95, P=10 -> closes on the 10th post-open edge; cycles=10, ref=100. GATE_CYCLES=101 -> cycles=11, ref=110.
4. TIMEOUT_CYCLES=200, sig_in held 0, start -> done at cycle ~200 after start; timeout=1, counts=0. Next start with a valid signal clears timeout.
5. abort raised in MEAS (with start high in the same cycle) -> busy=0 next cycle, no done, prior results unchanged. rest pulsed mid-MEAS -> all outputs 0.
6. CNT_W=8, GATE_CYCLES=300, P=10 -> ref saturates at 255, ovf=1.
